decoder_arbiter8: RTL and testbench

Round-robin arbiter that shares a single three_to_eight decoder between eight requesters. It selects one requester at a time, holds the grant until the owner releases, and drives the decoder's enable and select inputs so the decoder output is the one-hot grant vector. It sits between the requester blocks and the shared decoder, and also keeps a wrap-around grant counter for debug.

---
 rtl/decoder_arbiter8_if.sv | 21 ++
 rtl/decoder_arbiter8.sv | 148 ++++++++++++++
 tb/tb_decoder_arbiter8.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_arbiter8_if.sv
// Request/grant bundle between the requesters, the arbiter and the shared decoder.
// master: requester side; slave: arbiter side.
interface decoder_arbiter8_if;
    logic [7:0] Req;
    logic       Done;
    logic [2:0] GntIdx;
    logic       GntValid;
    logic [7:0] Gnt;
    logic [7:0] GrantCount;
    logic       Timeout;

    modport master (
        output Req, Done,
        input  GntIdx, GntValid, Gnt, GrantCount, Timeout
    );

    modport slave (
        input  Req, Done,
        output GntIdx, GntValid, Gnt, GrantCount, Timeout
    );
endinterface

// File: rtl/decoder_arbiter8.sv
// Round-robin arbiter sharing one three_to_eight decoder among eight requesters.
// Optional hold-time limit with forced release is built when ARB_TIMEOUT_EN is defined.
module three_to_eight (
    output logic [7:0] Out,
    input  logic       E,
    input  logic [2:0] Inp
);
    always_comb begin
        Out = 8'b0;
        if (E) Out[Inp] = 1'b1;
    end
endmodule

module decoder_arbiter8 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic               clk,
    input  logic               rst,
    decoder_arbiter8_if.slave  bus
);
    localparam int unsigned N_REQ  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned HOLD_W = 4;

    if (MAX_HOLD < 2 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("decoder_arbiter8: MAX_HOLD must be in 2..15");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]   r_gnt_idx, w_gnt_idx_nxt;
    logic               r_gnt_valid, w_gnt_valid_nxt;
    logic [CNT_W-1:0]   r_grant_count, w_grant_count_nxt;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_sel_found;
    logic               w_owner_req;
    logic               w_force;
    logic [N_REQ-1:0]   w_gnt;

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0]  r_hold_cnt, w_hold_cnt_nxt;
    logic               r_timeout, w_timeout_nxt;

    assign w_force = (r_state == GRANT) && (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
    assign w_force = 1'b0;
`endif

    assign w_owner_req = bus.Req[r_gnt_idx];

    // First set request searching cyclically upward from the pointer.
    always_comb begin
        w_sel_idx   = '0;
        w_sel_found = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            logic [IDX_W-1:0] idx;
            idx = r_ptr + IDX_W'(k);
            if (!w_sel_found && bus.Req[idx]) begin
                w_sel_idx   = idx;
                w_sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_gnt_idx_nxt     = r_gnt_idx;
        w_gnt_valid_nxt   = r_gnt_valid;
        w_grant_count_nxt = r_grant_count;
`ifdef ARB_TIMEOUT_EN
        w_hold_cnt_nxt    = r_hold_cnt;
        w_timeout_nxt     = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_sel_found) begin
                    w_state_nxt       = GRANT;
                    w_gnt_idx_nxt     = w_sel_idx;
                    w_gnt_valid_nxt   = 1'b1;
                    w_grant_count_nxt = r_grant_count + CNT_W'(1);
`ifdef ARB_TIMEOUT_EN
                    w_hold_cnt_nxt    = '0;
`endif
                end
            end
            GRANT: begin
                if (bus.Done || !w_owner_req || w_force) begin
                    w_state_nxt     = IDLE;
                    w_gnt_valid_nxt = 1'b0;
                    w_ptr_nxt       = r_gnt_idx + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
                    // Only flag a forced release when nothing else caused it.
                    w_timeout_nxt   = w_force && !bus.Done && w_owner_req;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    w_hold_cnt_nxt  = r_hold_cnt + HOLD_W'(1);
`endif
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_gnt_idx     <= '0;
            r_gnt_valid   <= 1'b0;
            r_grant_count <= '0;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt    <= '0;
            r_timeout     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_gnt_idx     <= w_gnt_idx_nxt;
            r_gnt_valid   <= w_gnt_valid_nxt;
            r_grant_count <= w_grant_count_nxt;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_timeout     <= w_timeout_nxt;
`endif
        end
    end

    three_to_eight u_dec (
        .Out (w_gnt),
        .E   (r_gnt_valid),
        .Inp (r_gnt_idx)
    );

    assign bus.Gnt        = w_gnt;
    assign bus.GntIdx     = r_gnt_idx;
    assign bus.GntValid   = r_gnt_valid;
    assign bus.GrantCount = r_grant_count;
`ifdef ARB_TIMEOUT_EN
    assign bus.Timeout    = r_timeout;
`else
    assign bus.Timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_decoder_arbiter8.sv
// Directed self-checking bench for decoder_arbiter8 (MAX_HOLD=4; covers both ARB_TIMEOUT_EN builds).
module tb_decoder_arbiter8;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [7:0] exp_cnt;

    decoder_arbiter8_if bus ();

    decoder_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.Req  = 8'h00;
        bus.Done = 1'b0;
        repeat (2) tick();
        rst     = 1'b0;
        exp_cnt = 8'd0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        bus.Req  = 8'h00;
        bus.Done = 1'b0;
        #2;
        n_checks++;
        if (bus.GntValid !== 1'b0 || bus.Gnt !== 8'h00 || bus.GntIdx !== 3'd0 ||
            bus.GrantCount !== 8'd0 || bus.Timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: valid=%b gnt=%b idx=%0d cnt=%0d tmo=%b, want 0,00000000,0,0,0",
                     bus.GntValid, bus.Gnt, bus.GntIdx, bus.GrantCount, bus.Timeout);
        end
        repeat (2) tick();
        rst     = 1'b0;
        exp_cnt = 8'd0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (bus.GntValid !== 1'b0 || bus.Gnt !== 8'h00 || bus.GrantCount !== 8'd0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: valid=%b gnt=%b cnt=%0d, want 0,00000000,0",
                         c, bus.GntValid, bus.Gnt, bus.GrantCount);
            end
        end
    endtask

    task automatic test_single();
        bus.Req = 8'b0001_0000;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) exp_cnt++;
            n_checks++;
            if (bus.GntValid !== 1'b1 || bus.GntIdx !== 3'd4 || bus.Gnt !== 8'b0001_0000 ||
                bus.GrantCount !== exp_cnt) begin
                n_fail++;
                $display("FAIL single_grant_c%0d: valid=%b idx=%0d gnt=%b cnt=%0d, want 1,4,00010000,%0d",
                         c, bus.GntValid, bus.GntIdx, bus.Gnt, bus.GrantCount, exp_cnt);
            end
        end
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
        n_checks++;
        if (bus.GntValid !== 1'b0 || bus.Gnt !== 8'h00 || bus.GntIdx !== 3'd4) begin
            n_fail++;
            $display("FAIL single_bubble: valid=%b gnt=%b idx=%0d, want 0,00000000,4",
                     bus.GntValid, bus.Gnt, bus.GntIdx);
        end
        tick();
        exp_cnt++;
        n_checks++;
        if (bus.GntValid !== 1'b1 || bus.GntIdx !== 3'd4 || bus.GrantCount !== 8'd2) begin
            n_fail++;
            $display("FAIL single_regrant: valid=%b idx=%0d cnt=%0d, want 1,4,2",
                     bus.GntValid, bus.GntIdx, bus.GrantCount);
        end
        bus.Req = 8'h00;
        tick();
    endtask

    task automatic test_round_robin();
        logic [2:0] order [6];
        order = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2, 3'd7};
        do_reset();
        bus.Req  = 8'b1000_0101;
        bus.Done = 1'b1;
        for (int g = 0; g < 6; g++) begin
            tick();
            exp_cnt++;
            n_checks++;
            if (bus.GntValid !== 1'b1 || bus.GntIdx !== order[g] ||
                bus.Gnt !== (8'h01 << order[g]) || bus.GrantCount !== exp_cnt) begin
                n_fail++;
                $display("FAIL rr_grant%0d: valid=%b idx=%0d gnt=%b cnt=%0d, want 1,%0d,cnt %0d",
                         g, bus.GntValid, bus.GntIdx, bus.Gnt, bus.GrantCount, order[g], exp_cnt);
            end
            tick();
            n_checks++;
            if (bus.GntValid !== 1'b0 || bus.Gnt !== 8'h00) begin
                n_fail++;
                $display("FAIL rr_bubble%0d: valid=%b gnt=%b, want 0,00000000",
                         g, bus.GntValid, bus.Gnt);
            end
        end
        bus.Done = 1'b0;
        bus.Req  = 8'h00;
        tick();
    endtask

    task automatic test_withdraw();
        do_reset();
        bus.Req = 8'b0000_1000;
        tick();
        n_checks++;
        if (bus.GntValid !== 1'b1 || bus.GntIdx !== 3'd3) begin
            n_fail++;
            $display("FAIL withdraw_grant: valid=%b idx=%0d, want 1,3", bus.GntValid, bus.GntIdx);
        end
        bus.Req = 8'b0010_0001;
        tick();
        n_checks++;
        if (bus.GntValid !== 1'b0 || bus.Timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL withdraw_release: valid=%b tmo=%b, want 0,0", bus.GntValid, bus.Timeout);
        end
        tick();
        n_checks++;
        if (bus.GntValid !== 1'b1 || bus.GntIdx !== 3'd5 || bus.Gnt !== 8'b0010_0000) begin
            n_fail++;
            $display("FAIL withdraw_next: valid=%b idx=%0d gnt=%b, want 1,5,00100000",
                     bus.GntValid, bus.GntIdx, bus.Gnt);
        end
        bus.Req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.Req = 8'b0000_0010;
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_checks++;
            if (bus.GntValid !== 1'b1 || bus.GntIdx !== 3'd1 || bus.Timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL tmo_hold_c%0d: valid=%b idx=%0d tmo=%b, want 1,1,0",
                         c, bus.GntValid, bus.GntIdx, bus.Timeout);
            end
        end
        tick();
        n_checks++;
        if (bus.GntValid !== 1'b0 || bus.Timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_release: valid=%b tmo=%b, want 0,1", bus.GntValid, bus.Timeout);
        end
        tick();
        n_checks++;
        if (bus.GntValid !== 1'b1 || bus.GntIdx !== 3'd1 || bus.Timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_regrant: valid=%b idx=%0d tmo=%b, want 1,1,0",
                     bus.GntValid, bus.GntIdx, bus.Timeout);
        end
`else
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_checks++;
            if (bus.GntValid !== 1'b1 || bus.GntIdx !== 3'd1 || bus.Timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL notmo_hold_c%0d: valid=%b idx=%0d tmo=%b, want 1,1,0",
                         c, bus.GntValid, bus.GntIdx, bus.Timeout);
            end
        end
`endif
        bus.Done = 1'b1;
        bus.Req  = 8'h00;
        tick();
        bus.Done = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.Req  = 8'b0100_0000;
        bus.Done = 1'b1;
        tick();
        tick();
        bus.Done = 1'b0;
        tick();
        n_checks++;
        if (bus.GntValid !== 1'b1 || bus.GntIdx !== 3'd6 || bus.GrantCount !== 8'd2) begin
            n_fail++;
            $display("FAIL mid_pre: valid=%b idx=%0d cnt=%0d, want 1,6,2",
                     bus.GntValid, bus.GntIdx, bus.GrantCount);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.GntValid !== 1'b0 || bus.Gnt !== 8'h00 || bus.GrantCount !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_async: valid=%b gnt=%b cnt=%0d, want 0,00000000,0",
                     bus.GntValid, bus.Gnt, bus.GrantCount);
        end
        tick();
        rst     = 1'b0;
        bus.Req = 8'b1100_0001;
        tick();
        n_checks++;
        if (bus.GntValid !== 1'b1 || bus.GntIdx !== 3'd0 || bus.Gnt !== 8'h01) begin
            n_fail++;
            $display("FAIL mid_restart: valid=%b idx=%0d gnt=%b, want 1,0,00000001",
                     bus.GntValid, bus.GntIdx, bus.Gnt);
        end
        bus.Req = 8'h00;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        bus.Req  = 8'h01;
        bus.Done = 1'b1;
        for (int g = 1; g <= 256; g++) begin
            tick();
            exp_cnt++;
            if (g == 1 || g == 255 || g == 256) begin
                n_checks++;
                if (bus.GrantCount !== exp_cnt || bus.GntValid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap_g%0d: cnt=%0d valid=%b, want %0d,1",
                             g, bus.GrantCount, bus.GntValid, exp_cnt);
                end
            end
            tick();
        end
        n_checks++;
        if (bus.GrantCount !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_final: cnt=%0d, want 0", bus.GrantCount);
        end
        bus.Done = 1'b0;
        bus.Req  = 8'h00;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 8'd0;
        rst      = 1'b1;
        bus.Req  = 8'h00;
        bus.Done = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_withdraw();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
